// File: rtl/mem_pkg.sv
// Shared definitions for the memory block and the core it talks to over uni_bus.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  // Command FSM states; any other encoding is treated as IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/memory.sv
// Single-port word memory on a shared tri-state bus.
// A command is one req strobe and is followed by exactly one busy cycle.
// In a read, the block drives the stored word onto uni_bus during that cycle.
// In a write, the block captures uni_bus at the edge that closes that cycle.
module memory
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] uni_bus,
  output logic              busy,
  output logic              rvalid
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Address taken modulo DEPTH, so a non-power-of-two depth never indexes past the array.
  assign w_idx = IDX_W'(32'(addr_q) % 32'(DEPTH));

  // State and address register; reset wins over a simultaneous req.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) addr_q <= addr;
    end
  end

  // Next state and status outputs; req outside IDLE is dropped, not queued.
  always_comb begin
    state_nxt = IDLE;
    busy      = 1'b0;
    rvalid    = 1'b0;
    case (state)
      IDLE:  if (req) state_nxt = rd ? READ : WRITE;
      READ:  begin busy = 1'b1; rvalid = 1'b1; end
      WRITE: busy = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage write at the edge closing WRITE; an aborting reset suppresses it, contents never cleared.
  always_ff @(posedge CLK) begin
    if (!RST && state == WRITE) mem[w_idx] <= uni_bus;
  end

  // The bus is driven only for the single READ cycle.
  assign uni_bus = (state == READ) ? mem[w_idx] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory. Each stimulus step queues the outputs expected after the next edge.
// The monitor pops one expectation per edge and compares busy, rvalid and the resolved bus.
// The bench parks a known value on the bus whenever the DUT must not drive it.
module tb_memory;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       drv_en  = 1'b1;
  logic [7:0] drv_val = 8'h00;
  wire  [7:0] uni_bus;
  logic       busy, rvalid;

  assign uni_bus = drv_en ? drv_val : 8'hzz;

  memory #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
    .CLK(CLK), .RST(RST), .req(req), .rd(rd), .addr(addr),
    .uni_bus(uni_bus), .busy(busy), .rvalid(rvalid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       busy;
    logic       rvalid;
    logic [7:0] bus;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // One cycle of stimulus. The inputs are sampled at the next rising edge.
  // The bus drive holds across the check that follows that edge.
  // Expectation: outputs and bus value right after that edge.
  task automatic step(input string nm, input logic r, input logic rq, input logic rdi,
                      input logic [7:0] a, input logic de, input logic [7:0] dv,
                      input logic eb, input logic ev, input logic [7:0] ebus);
    exp_t e;
    @(negedge CLK);
    RST = r; req = rq; rd = rdi; addr = a; drv_en = de; drv_val = dv;
    e.busy = eb; e.rvalid = ev; e.bus = ebus; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: compares the DUT against the queued expectation after every edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_vec++;
        if (busy !== e.busy) begin
          n_err++;
          $display("FAIL %s busy got %0b want %0b", e.name, busy, e.busy);
        end
        if (rvalid !== e.rvalid) begin
          n_err++;
          $display("FAIL %s rvalid got %0b want %0b", e.name, rvalid, e.rvalid);
        end
        if (uni_bus !== e.bus) begin
          n_err++;
          $display("FAIL %s uni_bus got %h want %h", e.name, uni_bus, e.bus);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    dut.mem[0] = 8'h10;
    dut.mem[1] = 8'h11;
    dut.mem[2] = 8'h12;
    dut.mem[3] = 8'h13;

    //    name            rst req rd addr   drv  val    busy rv bus
    step("reset0",        1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    step("reset1",        1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    // preloaded read of address 1
    step("rd1",           0, 1, 1, 8'h01, 0, 8'h00, 1, 1, 8'h11);
    step("rd1_end",       0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    // back-to-back reads
    step("b2b_a0",        0, 1, 1, 8'h00, 0, 8'h00, 1, 1, 8'h10);
    step("b2b_gap",       0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    step("b2b_a1",        0, 1, 1, 8'h01, 0, 8'h00, 1, 1, 8'h11);
    step("b2b_end",       0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    // writes to the top two addresses, then read-back
    step("wr_ff_req",     0, 1, 0, 8'hFF, 1, 8'h00, 1, 0, 8'h00);
    step("wr_ff_data",    0, 0, 0, 8'h00, 1, 8'hAA, 0, 0, 8'hAA);
    step("wr_fe_req",     0, 1, 0, 8'hFE, 1, 8'h00, 1, 0, 8'h00);
    step("wr_fe_data",    0, 0, 0, 8'h00, 1, 8'hAB, 0, 0, 8'hAB);
    step("rd_ff",         0, 1, 1, 8'hFF, 0, 8'h00, 1, 1, 8'hAA);
    step("rd_ff_end",     0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    step("rd_fe",         0, 1, 1, 8'hFE, 0, 8'h00, 1, 1, 8'hAB);
    step("rd_fe_end",     0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    // write then immediate read of the same address
    step("wr80_req",      0, 1, 0, 8'h80, 1, 8'h00, 1, 0, 8'h00);
    step("wr80_data",     0, 0, 0, 8'h00, 1, 8'h5C, 0, 0, 8'h5C);
    step("rd80",          0, 1, 1, 8'h80, 0, 8'h00, 1, 1, 8'h5C);
    step("rd80_end",      0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    // req while busy is dropped
    step("rd3",           0, 1, 1, 8'h03, 0, 8'h00, 1, 1, 8'h13);
    step("rd2_ignored",   0, 1, 1, 8'h02, 1, 8'h00, 0, 0, 8'h00);
    step("after_ignored", 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    // reset in the middle of a write
    step("wr0_req",       0, 1, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00);
    step("wr0_rst",       1, 0, 0, 8'h00, 1, 8'h55, 0, 0, 8'h55);
    step("rd0_after_rst", 0, 1, 1, 8'h00, 0, 8'h00, 1, 1, 8'h10);
    step("rd0_end",       0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    // reset and req together
    step("rst_req",       1, 1, 1, 8'h01, 1, 8'h33, 0, 0, 8'h33);
    step("rst_req_end",   0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    // read after reset priority shows the block still works
    step("rd2",           0, 1, 1, 8'h02, 0, 8'h00, 1, 1, 8'h12);
    step("rd2_end",       0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);

    repeat (3) @(posedge CLK);
    #5;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
